// File: rtl/control_giro_fsm.sv
// control_giro_fsm: phase sequencer for the turn-arrow and pedestrian semaphores.
//
// Cycles main-road green, all-red clearance, turn-arrow green and an optional
// on-demand pedestrian walk phase. Durations are counted in `tick` pulses.
//
// Build option: define SEMAFORO_PEATON_EN to include the pedestrian phase and the
// request latch. Without it, CLR_B always returns to MAIN, `ped_req` is ignored and
// `ped_ack`/`light_peaton` are held at 0.
//
// Parameters:
//   T_MAIN, T_CLEAR, T_GIRO, T_PEATON - phase durations in ticks (>= 1)
//   CNT_W                             - counter width, must hold max(T_*) - 1
// Ports:
//   clk          in  system clock, rising edge
//   rst          in  asynchronous active-high reset
//   tick         in  one-clk enable; timing advances only when high
//   ped_req      in  pedestrian button, sampled every clk
//   light_giro   out turn semaphore code (00 red, 10 green)
//   light_peaton out pedestrian semaphore code (00 red, 10 green)
//   main_go      out main road may show green
//   ped_ack      out pedestrian request pending
//   phase        out current state encoding

module control_giro_fsm #(
  parameter int unsigned T_MAIN   = 10,
  parameter int unsigned T_CLEAR  = 2,
  parameter int unsigned T_GIRO   = 5,
  parameter int unsigned T_PEATON = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  output logic [1:0] light_giro,
  output logic [1:0] light_peaton,
  output logic       main_go,
  output logic       ped_ack,
  output logic [2:0] phase
);

  localparam logic [1:0] LightRed   = 2'b00;
  localparam logic [1:0] LightGreen = 2'b10;

  typedef enum logic [2:0] {
    StMain   = 3'd0,
    StClrA   = 3'd1,
    StGiro   = 3'd2,
    StClrB   = 3'd3,
    StPeaton = 3'd4,
    StClrC   = 3'd5
  } state_e;

  // Reload value for the tick counter on entry to a state.
  function automatic logic [CNT_W-1:0] load_val(input state_e st);
    logic [CNT_W-1:0] v;
    v = CNT_W'(T_CLEAR - 1);
    case (st)
      StMain:   v = CNT_W'(T_MAIN - 1);
      StGiro:   v = CNT_W'(T_GIRO - 1);
      StPeaton: v = CNT_W'(T_PEATON - 1);
      default:  v = CNT_W'(T_CLEAR - 1);
    endcase
    return v;
  endfunction

  state_e           state_q, state_d;
  state_e           follow;
  logic             state_ok;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       light_giro_q, light_giro_d;
  logic [1:0]       light_peaton_q, light_peaton_d;
  logic             main_go_q, main_go_d;
  logic             ped_pend_q, ped_pend_d;

  // Next-state and counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    follow   = StClrC;
    state_ok = 1'b1;

    case (state_q)
      StMain: follow = StClrA;
      StClrA: follow = StGiro;
      StGiro: follow = StClrB;
`ifdef SEMAFORO_PEATON_EN
      StClrB:   follow = ped_pend_q ? StPeaton : StMain;
      StPeaton: follow = StClrC;
`else
      StClrB: follow = StMain;
`endif
      StClrC:  follow = StMain;
      default: state_ok = 1'b0;
    endcase

    if (!state_ok) begin
      // Unreachable encodings fall back to clearance without waiting for a tick.
      state_d = StClrC;
      cnt_d   = load_val(StClrC);
    end else if (tick) begin
      if (cnt_q == '0) begin
        state_d = follow;
        cnt_d   = load_val(follow);
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

`ifdef SEMAFORO_PEATON_EN
  // Request latch: set anywhere but PEATON, cleared on entry to PEATON (clear wins).
  always_comb begin
    ped_pend_d = ped_pend_q;
    if (ped_req && (state_q != StPeaton)) begin
      ped_pend_d = 1'b1;
    end
    if ((state_d == StPeaton) && (state_q != StPeaton)) begin
      ped_pend_d = 1'b0;
    end
  end
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign ped_pend_d     = 1'b0;
`endif

  // Outputs are decoded from the next state so they register with the phase.
  always_comb begin
    main_go_d      = 1'b0;
    light_giro_d   = LightRed;
    light_peaton_d = LightRed;
    case (state_d)
      StMain:   main_go_d = 1'b1;
      StGiro:   light_giro_d = LightGreen;
`ifdef SEMAFORO_PEATON_EN
      StPeaton: light_peaton_d = LightGreen;
`endif
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StClrC;
      cnt_q          <= CNT_W'(T_CLEAR - 1);
      light_giro_q   <= LightRed;
      light_peaton_q <= LightRed;
      main_go_q      <= 1'b0;
      ped_pend_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      light_giro_q   <= light_giro_d;
      light_peaton_q <= light_peaton_d;
      main_go_q      <= main_go_d;
      ped_pend_q     <= ped_pend_d;
    end
  end

  assign phase        = state_q;
  assign light_giro   = light_giro_q;
  assign light_peaton = light_peaton_q;
  assign main_go      = main_go_q;
  assign ped_ack      = ped_pend_q;

endmodule

// File: tb/tb_control_giro_fsm.sv
// Scoreboard bench for control_giro_fsm with T_MAIN=3, T_CLEAR=1, T_GIRO=2,
// T_PEATON=2. Stimulus pushes the expected phase/ped_ack after each clk edge;
// the monitor pops on the following falling edge (or just after an asynchronous
// reset) and checks phase plus the lights and main_go implied by that phase.

module tb_control_giro_fsm;

`ifdef SEMAFORO_PEATON_EN
  localparam logic P = 1'b1;
`else
  localparam logic P = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] light_giro;
  logic [1:0] light_peaton;
  logic       main_go;
  logic       ped_ack;
  logic [2:0] phase;

  control_giro_fsm #(
    .T_MAIN  (3),
    .T_CLEAR (1),
    .T_GIRO  (2),
    .T_PEATON(2),
    .CNT_W   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .ped_req     (ped_req),
    .light_giro  (light_giro),
    .light_peaton(light_peaton),
    .main_go     (main_go),
    .ped_ack     (ped_ack),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ph;
    logic        ack;
    logic [15:0] idx;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned step_no = 0;

  function automatic void cmp(input string name, input int unsigned idx,
                              input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endfunction

  // Monitor: one expectation per falling edge, or right after reset asserts.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge rst);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cmp("phase", e.idx, phase, e.ph);
        cmp("light_giro", e.idx, {1'b0, light_giro}, (e.ph == 3'd2) ? 3'd2 : 3'd0);
        cmp("light_peaton", e.idx, {1'b0, light_peaton}, (e.ph == 3'd4) ? 3'd2 : 3'd0);
        cmp("main_go", e.idx, {2'b0, main_go}, {2'b0, (e.ph == 3'd0)});
        cmp("ped_ack", e.idx, {2'b0, ped_ack}, {2'b0, e.ack});
      end
    end
  end

  task automatic push_exp(input logic [2:0] ph, input logic ack);
    exp_t e;
    e.ph  = ph;
    e.ack = ack;
    e.idx = step_no[15:0];
    exp_q.push_back(e);
    step_no++;
  endtask

  // Drive inputs while clk is low; expected values describe the state after the edge.
  task automatic step(input logic t, input logic r, input logic [2:0] ph, input logic ack);
    tick    = t;
    ped_req = r;
    @(posedge clk);
    push_exp(ph, ack);
    @(negedge clk);
  endtask

  task automatic round(input logic r);
    step(1, r, 0, 0); step(1, r, 0, 0); step(1, r, 0, 0); step(1, r, 1, 0);
    step(1, r, 2, 0); step(1, r, 2, 0); step(1, r, 3, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    // Held in reset across clock edges.
    step(1, 0, 5, 0);
    step(1, 0, 5, 0);
    rst = 1'b0;

    // No requests: 7-cycle loop, leaving CLR_B with cnt=0.
    round(1'b0);
    round(1'b0);

`ifdef SEMAFORO_PEATON_EN
    // Pulse in MAIN, then hold the button only during PEATON.
    step(1, 0, 0, 0); step(1, 1, 0, 1); step(1, 0, 0, 1); step(1, 0, 1, 1);
    step(1, 0, 2, 1); step(1, 0, 2, 1); step(1, 0, 3, 1);
    step(1, 0, 4, 0); step(1, 1, 4, 0); step(1, 1, 5, 0);
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 1, 0);
    step(1, 0, 2, 0); step(1, 0, 2, 0); step(1, 0, 3, 0); step(1, 0, 0, 0);
`else
    // Button held: no pedestrian phase, no acknowledge.
    round(1'b1);
    round(1'b1);
    step(1, 1, 0, 0);
`endif

    // Just entered MAIN. Tick every 4th clk: MAIN spans 12 clk.
    for (int k = 0; k < 3; k++) begin
      repeat (3) step(0, 0, 0, 0);
      step(1, 0, (k < 2) ? 3'd0 : 3'd1, 0);
    end
    repeat (3) step(0, 0, 1, 0);
    step(1, 0, 2, 0);
    repeat (3) step(0, 0, 2, 0);
    step(1, 0, 2, 0);
    repeat (3) step(0, 0, 2, 0);
    step(1, 0, 3, 0);

    // Asynchronous reset while in GIRO, with a request pending.
    step(1, 0, 0, 0); step(1, 1, 0, P); step(1, 0, 0, P); step(1, 0, 1, P);
    step(1, 0, 2, P);
    #2;
    push_exp(5, 0);
    rst = 1'b1;
    step(1, 0, 5, 0);
    rst = 1'b0;
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 1, 0);

    @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_giro_fsm.md
# control_giro_fsm

Phase sequencer that produces the 2-bit light codes consumed by the turn-arrow and pedestrian `semaforo2` instances. It cycles main-road green, all-red clearance, turn green, and an optional on-demand pedestrian walk phase. Durations are counted in `tick` pulses from the shared 1 Hz prescaler, and `main_go` tells the main-road controller when it may show green. It sits between the prescaler and the `semaforo2` light drivers in the CLOCK5 top level.

## Interface
- `T_MAIN`, 10: main-road green duration, in ticks (≥1)
- `T_CLEAR`, 2: all-red clearance duration, in ticks (≥1)
- `T_GIRO`, 5: turn-arrow green duration, in ticks (≥1)
- `T_PEATON`, 8: pedestrian walk duration, in ticks (≥1)
- `CNT_W`, 4: counter width; must hold max(T_*)−1
- `clk` in 1: system clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `tick` in 1: one-`clk` enable pulse; all timing advances only on cycles with `tick`=1
- `ped_req` in 1: pedestrian button, level or pulse, sampled every `clk`
- `light_giro` out 2: light code for the turn semaphore
- `light_peaton` out 2: light code for the pedestrian semaphore
- `main_go` out 1: 1 = main road may show green
- `ped_ack` out 1: pedestrian request pending (button lamp)
- `phase` out 3: current state encoding, for debug and bench

## Operation
- Light codes: RED = 2'b00, GREEN = 2'b10. The block never drives 01 or 11.
- States and encoding: MAIN=0, CLR_A=1, GIRO=2, CLR_B=3, PEATON=4, CLR_C=5. Codes 6 and 7 are unreachable and recover to CLR_C on the next `clk`.
- Transition sequence:
  - MAIN → CLR_A → GIRO → CLR_B.
  - CLR_B → PEATON if `ped_pend`=1 on the exiting cycle, else CLR_B → MAIN.
  - PEATON → CLR_C → MAIN.
- Outputs per state:
  - MAIN: `main_go`=1, `light_giro`=00, `light_peaton`=00.
  - GIRO: `light_giro`=10; all others RED/0.
  - PEATON: `light_peaton`=10; all others RED/0.
  - CLR_*: all RED, `main_go`=0.
- Counter `cnt`, CNT_W bits:
  - Loaded with T_state−1 on entry to each state.
  - Decrements on `tick`=1 while `cnt`≠0.
  - State exits on the `clk` edge where `tick`=1 and `cnt`=0. Each state therefore lasts exactly T_state ticks.
  - `cnt` never wraps below 0.
- Pedestrian latch `ped_pend` (drives `ped_ack`):
  - Set by `ped_req`=1 in any state except PEATON.
  - Cleared on the edge entering PEATON; clear wins over a simultaneous set.
  - A request made during PEATON is dropped.
  - A request made during CLR_C or MAIN is served after the next GIRO.

## Timing
- All outputs are registered and update on the same `clk` edge as `phase`. Latency from the decisive `tick` to the new lights is 1 `clk`.
- `ped_req` → `ped_ack`=1 on the next `clk` edge.
- Reset values while `rst`=1 (asynchronous):
  - `phase`=CLR_C, `cnt`=T_CLEAR−1.
  - `light_giro`=00, `light_peaton`=00, `main_go`=0, `ped_ack`=0.
- Reset mid-operation drops the lights to all-RED immediately, without waiting for `clk`.
- After `rst` falls, the block spends T_CLEAR ticks in CLR_C, then enters MAIN.
- `tick`=0 freezes `cnt` and `phase`; only the `ped_pend` set path stays active.
- `tick` held at 1 counts every `clk`; this is legal and used by the bench.

## Configuration
- `SEMAFORO_PEATON_EN` defined: full behaviour as above.
- `SEMAFORO_PEATON_EN` undefined:
  - PEATON and the pedestrian latch are removed.
  - CLR_B always exits to MAIN.
  - `ped_req` is ignored, `ped_ack`=0, `light_peaton`=00 constant.
  - CLR_C remains, used only as the reset/recovery state.

## Test plan
Bench parameters unless noted: T_MAIN=3, T_CLEAR=1, T_GIRO=2, T_PEATON=2, `tick`=1 constant.
- No request: after reset release, `phase` reads 5,0,0,0,1,2,2,3,0… (7-cycle loop). `light_peaton`=00 throughout; `main_go`=1 only in phase 0.
- One-cycle `ped_req` pulse in MAIN → `ped_ack`=1 next edge. After CLR_B, `phase` goes 4,4 with `light_peaton`=10, then 5, then 0. `ped_ack`=0 from PEATON entry onward.
- `ped_req` held only during PEATON → `ped_ack` stays 0; the following round goes CLR_B→MAIN.
- `tick` pulsed every 4th `clk` → MAIN lasts 12 `clk` (3 ticks); `phase` and `light_*` are stable between ticks.
- Assert `rst` asynchronously while `phase`=2 → `light_giro`=00, `phase`=5, `main_go`=0 with no `clk` edge. After release, `phase` is 5 for 1 tick, then 0.
- Build without `SEMAFORO_PEATON_EN`, `ped_req`=1 constant → `phase` never reads 4, `ped_ack`=0, `light_peaton`=00.
